conv2d_mac_tile_seq: RTL and testbench

Time-multiplexed 2D convolution engine, successor to the fully-parallel tile. It accepts one KxK window covering all IN_CH channels over a valid/ready handshake. For each group of TILE_OUT_CH output channels it iterates over IN_CH/TILE_IN_CH input-channel tiles, adds a per-channel bias, optionally applies ReLU, saturates, and emits one result beat per output group. It sits between the line-buffer/window generator and the requantizer in the conv datapath.

---
 rtl/conv2d_mac_tile_seq.sv | 178 +++++++++++++++++
 tb/tb_conv2d_mac_tile_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_mac_tile_seq.sv
// Time-multiplexed KxK convolution engine: one window in, N_OG result beats out.
// Each output group accumulates N_IT input-channel tiles, then adds bias, applies optional ReLU and saturates.
module conv2d_mac_tile_seq #(
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 32,
  parameter int IN_CH       = 16,
  parameter int OUT_CH      = 16,
  parameter int K           = 3,
  parameter int TILE_IN_CH  = 4,
  parameter int TILE_OUT_CH = 4,
  localparam int N_OG = OUT_CH / TILE_OUT_CH,
  localparam int GW   = (N_OG > 1) ? $clog2(N_OG) : 1,
  localparam int AW   = $clog2(OUT_CH * IN_CH * K * K)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            win_valid,
  output logic                            win_ready,
  input  logic [K*K*IN_CH*DATA_W-1:0]     win_data,
  input  logic                            relu_en,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TILE_OUT_CH*ACC_W-1:0]    out_data,
  output logic [GW-1:0]                   out_grp,
  output logic                            out_last,
  input  logic                            cfg_write,
  input  logic                            cfg_bias,
  input  logic [AW-1:0]                   cfg_addr,
  input  logic [ACC_W-1:0]                cfg_wdata,
  output logic                            cfg_err
);

  localparam int N_IT    = IN_CH / TILE_IN_CH;
  localparam int KK      = K * K;
  localparam int W_DEPTH = OUT_CH * IN_CH * KK;
  localparam int INT_W   = 2 * DATA_W + $clog2(IN_CH * KK) + 1;
  // Bias is ACC_W wide and may exceed INT_W, so the sum is widened to hold both.
  localparam int SW      = ((INT_W > ACC_W) ? INT_W : ACC_W) + 1;
  localparam int ITW     = (N_IT > 1) ? $clog2(N_IT) : 1;
  localparam int BW      = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

  if (IN_CH % TILE_IN_CH != 0) begin : g_bad_in_tile
    $error("IN_CH must be a multiple of TILE_IN_CH");
  end
  if (OUT_CH % TILE_OUT_CH != 0) begin : g_bad_out_tile
    $error("OUT_CH must be a multiple of TILE_OUT_CH");
  end

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_OUTPUT} state_t;
  state_t state, state_n;

  logic signed [DATA_W-1:0] w_mem [W_DEPTH];
  logic signed [ACC_W-1:0]  b_mem [OUT_CH];
  logic [K*K*IN_CH*DATA_W-1:0] win_q;

  logic                           relu_q;
  logic [GW-1:0]                  og;
  logic [ITW-1:0]                 it;
  logic [TILE_OUT_CH*INT_W-1:0]   acc, acc_sum;
  logic [TILE_OUT_CH*ACC_W-1:0]   res;
  logic accept, load_out, next_grp, last_it, last_grp, cfg_ok;

  int unsigned                oc, ic;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [INT_W-1:0]    sum;
  logic signed [SW-1:0]       s;
  logic [SW-ACC_W:0]          hi;

  assign win_ready = (state == S_IDLE);
  assign out_valid = (state == S_OUTPUT);
  assign last_it   = (it == ITW'(N_IT - 1));
  assign last_grp  = (og == GW'(N_OG - 1));
  assign cfg_ok    = cfg_write && (state == S_IDLE) && !win_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    load_out = 1'b0;
    next_grp = 1'b0;
    unique case (state)
      S_IDLE: if (win_valid) begin
        accept  = 1'b1;
        state_n = S_COMPUTE;
      end
      S_COMPUTE: if (last_it) begin
        load_out = 1'b1;
        state_n  = S_OUTPUT;
      end
      S_OUTPUT: if (out_ready) begin
        if (last_grp) state_n = S_IDLE;
        else begin
          next_grp = 1'b1;
          state_n  = S_COMPUTE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // MAC tile plus the bias/ReLU/saturate stage that is registered on the final tile.
  always_comb begin
    acc_sum = '0;
    res     = '0;
    oc      = 0;
    ic      = 0;
    prod    = '0;
    sum     = '0;
    s       = '0;
    hi      = '0;
    for (int unsigned o = 0; o < TILE_OUT_CH; o++) begin
      oc  = 32'(og) * TILE_OUT_CH + o;
      sum = $signed(acc[o*INT_W +: INT_W]);
      for (int unsigned i = 0; i < TILE_IN_CH; i++) begin
        ic = 32'(it) * TILE_IN_CH + i;
        for (int unsigned k = 0; k < KK; k++) begin
          prod = (2*DATA_W)'($signed(win_q[(k*IN_CH + ic)*DATA_W +: DATA_W]))
               * (2*DATA_W)'(w_mem[AW'(oc*IN_CH*KK + ic*KK + k)]);
          sum  = sum + INT_W'(prod);
        end
      end
      acc_sum[o*INT_W +: INT_W] = sum;
      s = SW'(sum) + SW'(b_mem[BW'(oc)]);
      if (relu_q && s[SW-1]) s = '0;
      hi = s[SW-1:ACC_W-1];
      if (hi == '0 || hi == '1) res[o*ACC_W +: ACC_W] = s[ACC_W-1:0];
      else if (s[SW-1])         res[o*ACC_W +: ACC_W] = {1'b1, {(ACC_W-1){1'b0}}};
      else                      res[o*ACC_W +: ACC_W] = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      og       <= '0;
      it       <= '0;
      acc      <= '0;
      relu_q   <= 1'b0;
      out_data <= '0;
      out_grp  <= '0;
      out_last <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_write && !cfg_ok;
      if (accept) begin
        og     <= '0;
        it     <= '0;
        acc    <= '0;
        relu_q <= relu_en;
      end else if (state == S_COMPUTE) begin
        acc <= acc_sum;
        it  <= last_it ? '0 : it + ITW'(1);
        if (load_out) begin
          out_data <= res;
          out_grp  <= og;
          out_last <= last_grp;
        end
      end else if (next_grp) begin
        og  <= og + GW'(1);
        it  <= '0;
        acc <= '0;
      end
    end
  end

  // Weight/bias memories and the window latch carry no reset; they survive rst.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      if (cfg_bias)                     b_mem[BW'(cfg_addr)] <= cfg_wdata;
      else if (32'(cfg_addr) < W_DEPTH) w_mem[cfg_addr]      <= cfg_wdata[DATA_W-1:0];
    end
    if (accept) win_q <= win_data;
  end

endmodule

// File: tb/tb_conv2d_mac_tile_seq.sv
// Randomized and directed bench for conv2d_mac_tile_seq at ACC_W=32 and ACC_W=16,
// checked against a plain-arithmetic convolution model.
module tb_conv2d_mac_tile_seq;
  localparam int DW = 8, IN = 16, OUT = 16, K = 3, TI = 4, TO = 4;
  localparam int KK = K * K, NW = OUT * IN * KK, N_OG = OUT / TO, N_IT = IN / TI;

  logic clk = 1'b0, rst;
  logic win_valid, relu_en, out_ready, cfg_write, cfg_bias;
  logic [KK*IN*DW-1:0] win_data;
  logic [11:0] cfg_addr;
  logic [31:0] cfg_wdata;

  logic win_ready_a, out_valid_a, out_last_a, cfg_err_a;
  logic [TO*32-1:0] out_data_a;
  logic [1:0] out_grp_a;
  logic win_ready_b, out_valid_b, out_last_b, cfg_err_b;
  logic [TO*16-1:0] out_data_b;
  logic [1:0] out_grp_b;

  int vectors = 0, miscompares = 0;
  int wt_m [NW];
  longint b32_m [OUT], b16_m [OUT];
  int win_m [KK*IN];

  always #5 clk = ~clk;

  conv2d_mac_tile_seq #(.DATA_W(DW), .ACC_W(32), .IN_CH(IN), .OUT_CH(OUT), .K(K),
                        .TILE_IN_CH(TI), .TILE_OUT_CH(TO)) dut_a (
    .clk(clk), .rst(rst), .win_valid(win_valid), .win_ready(win_ready_a), .win_data(win_data),
    .relu_en(relu_en), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_grp(out_grp_a), .out_last(out_last_a), .cfg_write(cfg_write), .cfg_bias(cfg_bias),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err_a));

  conv2d_mac_tile_seq #(.DATA_W(DW), .ACC_W(16), .IN_CH(IN), .OUT_CH(OUT), .K(K),
                        .TILE_IN_CH(TI), .TILE_OUT_CH(TO)) dut_b (
    .clk(clk), .rst(rst), .win_valid(win_valid), .win_ready(win_ready_b), .win_data(win_data),
    .relu_en(relu_en), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_grp(out_grp_b), .out_last(out_last_b), .cfg_write(cfg_write), .cfg_bias(cfg_bias),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata[15:0]), .cfg_err(cfg_err_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Expected output channel value: full dot product + bias, ReLU, then clamp to accw bits.
  function automatic longint exp_lane(input int oc, input bit relu, input int accw);
    longint s = 0, mx;
    for (int ic = 0; ic < IN; ic++)
      for (int k = 0; k < KK; k++)
        s += longint'(win_m[k*IN + ic]) * longint'(wt_m[oc*IN*KK + ic*KK + k]);
    s += (accw == 32) ? b32_m[oc] : b16_m[oc];
    if (relu && s < 0) s = 0;
    mx = (longint'(1) << (accw - 1)) - 1;
    if (s > mx) s = mx;
    if (s < -mx - 1) s = -mx - 1;
    return s;
  endfunction

  task automatic cfg_wr(input bit b, input int addr, input longint data);
    cfg_write = 1'b1; cfg_bias = b; cfg_addr = 12'(addr); cfg_wdata = 32'(data);
    tick;
    cfg_write = 1'b0;
    if (b) begin
      b32_m[addr] = longint'($signed(cfg_wdata));
      b16_m[addr] = longint'($signed(cfg_wdata[15:0]));
    end else wt_m[addr] = int'($signed(cfg_wdata[7:0]));
  endtask

  task automatic load_w(input bit rnd, input int c);
    for (int a = 0; a < NW; a++) cfg_wr(1'b0, a, rnd ? int'($urandom_range(255)) - 128 : c);
  endtask

  task automatic load_b(input bit rnd, input int c);
    for (int oc = 0; oc < OUT; oc++) cfg_wr(1'b1, oc, rnd ? longint'(int'($urandom)) : oc * c);
  endtask

  task automatic set_window(input bit rnd, input int c);
    for (int j = 0; j < KK*IN; j++) begin
      win_m[j] = rnd ? int'($urandom_range(255)) - 128 : c;
      win_data[j*DW +: DW] = 8'(win_m[j]);
    end
  endtask

  task automatic check_beat(input int g, input bit relu);
    chk("out_valid_a", out_valid_a, 1);
    chk("out_valid_b", out_valid_b, 1);
    chk("out_grp", out_grp_a, g);
    chk("out_grp_b", out_grp_b, g);
    chk("out_last", out_last_a, (g == N_OG - 1));
    for (int o = 0; o < TO; o++) begin
      chk($sformatf("lane32_g%0d_o%0d", g, o), $signed(out_data_a[o*32 +: 32]), exp_lane(g*TO + o, relu, 32));
      chk($sformatf("lane16_g%0d_o%0d", g, o), $signed(out_data_b[o*16 +: 16]), exp_lane(g*TO + o, relu, 16));
    end
  endtask

  // poke: 0 none, 1 cfg_write alongside the accept, 2 cfg_write during COMPUTE.
  task automatic run_window(input bit relu, input int stall_grp, input int stall_len, input int poke);
    int cyc, n;
    chk("win_ready_idle", win_ready_a, 1);
    relu_en = relu; win_valid = 1'b1;
    if (poke == 1) begin cfg_write = 1'b1; cfg_bias = 1'b0; cfg_addr = '0; cfg_wdata = 32'd5; end
    tick;
    cyc = 0; win_valid = 1'b0; relu_en = !relu;
    if (poke == 1) begin cfg_write = 1'b0; chk("cfg_err_accept", cfg_err_a, 1); end
    chk("win_ready_busy", win_ready_a, 0);
    for (int g = 0; g < N_OG; g++) begin
      n = 0;
      while (!out_valid_a && n < 40) begin
        if (poke == 2 && g == 0 && n == 0) begin
          cfg_write = 1'b1; cfg_bias = 1'b0; cfg_addr = '0; cfg_wdata = 32'd5;
        end
        tick; n++; cyc++;
        if (poke == 2 && g == 0 && n == 1) begin cfg_write = 1'b0; chk("cfg_err_busy", cfg_err_a, 1); end
        if (poke == 2 && g == 0 && n == 2) chk("cfg_err_one_cycle", cfg_err_a, 0);
      end
      chk("beat_latency", n, N_IT);
      check_beat(g, relu);
      if (g == stall_grp) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick; cyc++;
          check_beat(g, relu);
          chk("win_ready_stall", win_ready_a, 0);
        end
        out_ready = 1'b1;
      end
      tick; cyc++;
    end
    chk("win_ready_after", win_ready_a, 1);
    chk("out_valid_after", out_valid_a, 0);
    chk("window_cycles", cyc, N_OG*(N_IT+1) + ((stall_grp >= 0) ? stall_len : 0));
  endtask

  initial begin
    rst = 1'b1; win_valid = 1'b0; relu_en = 1'b0; out_ready = 1'b1;
    cfg_write = 1'b0; cfg_bias = 1'b0; cfg_addr = '0; cfg_wdata = '0; win_data = '0;
    repeat (2) tick;
    chk("rst_win_ready", win_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_out_grp", out_grp_a, 0);
    chk("rst_out_last", out_last_a, 0);
    chk("rst_cfg_err", cfg_err_a, 0);
    rst = 1'b0;
    tick;

    // All ones: every lane 144.
    load_w(1'b0, 1); load_b(1'b0, 0); set_window(1'b0, 1);
    chk("model_ones", exp_lane(5, 1'b0, 32), 144);
    run_window(1'b0, -1, 0, 0);

    // Weights -1, bias[oc]=oc: oc-144, and 0 under ReLU.
    load_w(1'b0, -1); load_b(1'b0, 1);
    run_window(1'b0, -1, 0, 0);
    run_window(1'b1, -1, 0, 0);

    // Large magnitudes: 2,322,576 fits 32 bits, clamps at 16 bits.
    set_window(1'b0, 127); load_w(1'b0, 127); load_b(1'b0, 0);
    chk("model_sat16_pos", exp_lane(0, 1'b0, 16), 32767);
    run_window(1'b0, -1, 0, 0);
    load_w(1'b0, -127);
    chk("model_sat16_neg", exp_lane(0, 1'b0, 16), -32768);
    run_window(1'b0, -1, 0, 0);

    // Random content with a 10-cycle stall on group 1.
    load_w(1'b1, 0); load_b(1'b1, 0); set_window(1'b1, 0);
    run_window(1'b0, 1, 10, 0);
    run_window(1'b1, -1, 0, 0);

    // Dropped cfg writes leave results unchanged; an idle write takes effect.
    load_w(1'b0, 1); load_b(1'b0, 0); set_window(1'b0, 1);
    run_window(1'b0, -1, 0, 2);
    run_window(1'b0, -1, 0, 1);
    cfg_wr(1'b0, 0, 5);
    chk("model_w5", exp_lane(0, 1'b0, 32), 148);
    run_window(1'b0, -1, 0, 0);

    for (int r = 0; r < 3; r++) begin
      load_w(1'b1, 0); load_b(1'b1, 0); set_window(1'b1, 0);
      run_window(1'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(1, 4)), 0);
    end

    // Reset in the middle of group 2.
    win_valid = 1'b1; tick; win_valid = 1'b0;
    repeat (12) tick;
    chk("pre_rst_grp", out_grp_a, 1);
    rst = 1'b1;
    #1;
    chk("arst_win_ready", win_ready_a, 1);
    chk("arst_out_valid", out_valid_a, 0);
    chk("arst_out_data", out_data_a, 0);
    chk("arst_out_grp", out_grp_a, 0);
    chk("arst_out_last", out_last_a, 0);
    chk("arst_cfg_err", cfg_err_a, 0);
    tick; rst = 1'b0; tick;
    run_window(1'b0, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
